// File: rtl/stereolbm_axis_cambm_lbuf_pkg.sv
// Shared types for the stereo LBM line-buffer address generator:
// widths, FSM state encoding and the per-stage pipeline record.
package stereolbm_axis_cambm_lbuf_pkg;

  localparam int ROW_W  = 6;
  localparam int COL_W  = 10;
  localparam int ADDR_W = 15;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             last;
    logic             first;
  } stage_t;

endpackage

// File: rtl/stereolbm_axis_cambm_lbuf_addr_gen_mul_reg.sv
// Registered unsigned multiply, result taken modulo 2^P_W.
// Ports: clk_i/rst_i (async high), en_i hold control, a_i x b_i -> p_o.
module stereolbm_axis_cambm_lbuf_mul_reg #(
  parameter int A_W = 6,
  parameter int B_W = 10,
  parameter int P_W = 15
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  output logic [P_W-1:0] p_o
);

  logic [P_W-1:0] a_ext;
  logic [P_W-1:0] b_ext;
  logic [P_W-1:0] p_d;

  // Operating at P_W bits drops the product's upper bits directly.
  assign a_ext = P_W'(a_i);
  assign b_ext = P_W'(b_i);
  assign p_d   = a_ext * b_ext;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_o <= '0;
    end else if (en_i) begin
      p_o <= p_d;
    end
  end

endmodule

// File: rtl/stereolbm_axis_cambm_lbuf_addr_gen.sv
// Raster-scan line-buffer address generator: row*width+col per beat.
// Ports: ap_* control, cfg_rows/cfg_width frame size, m_addr_* stream.
module stereolbm_axis_cambm_lbuf_addr_gen #(
  parameter int ROW_W  = 6,
  parameter int COL_W  = 10,
  parameter int ADDR_W = 15
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  input  logic [ROW_W-1:0]  cfg_rows,
  input  logic [COL_W-1:0]  cfg_width,
  output logic              ap_idle,
  output logic              ap_done,
  output logic [ADDR_W-1:0] m_addr_tdata,
  output logic              m_addr_tvalid,
  input  logic              m_addr_tready,
  output logic              m_addr_tlast,
  output logic              m_addr_tuser
);
  import stereolbm_axis_cambm_lbuf_pkg::*;

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  rows_q, row_q, row_d;
  logic [COL_W-1:0]  width_q, col_q, col_d;
  logic              done_q, done_d;
  stage_t            s2_q, s2_d, s3_q, s3_d;
  logic [ADDR_W-1:0] prod, sum_q, sum_d;
  logic              pipe_en, issue, accept, zero_dim;
  logic              row_end, frame_end, final_hs;

  // Stage 2 product; shares the pipeline enable with the stage records.
  stereolbm_axis_cambm_lbuf_mul_reg #(
    .A_W(ROW_W),
    .B_W(COL_W),
    .P_W(ADDR_W)
  ) u_mul (
    .clk_i(ap_clk),
    .rst_i(ap_rst),
    .en_i (pipe_en),
    .a_i  (row_q),
    .b_i  (width_q),
    .p_o  (prod)
  );

  always_comb begin
    pipe_en   = !s3_q.valid || m_addr_tready;
    accept    = (state_q == IDLE) && ap_start;
    zero_dim  = (cfg_rows == '0) || (cfg_width == '0);
    issue     = (state_q == RUN) && pipe_en;
    row_end   = col_q == width_q - COL_W'(1);
    frame_end = row_end && (row_q == rows_q - ROW_W'(1));
    // Only the frame's final beat sits on the last column of the last row.
    final_hs  = s3_q.valid && m_addr_tready
             && (s3_q.row == rows_q - ROW_W'(1))
             && (s3_q.col == width_q - COL_W'(1));
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ap_start) begin
          if (zero_dim) done_d  = 1'b1;
          else          state_d = RUN;
        end
      end
      RUN: begin
        if (issue && frame_end) state_d = DRAIN;
      end
      DRAIN: begin
        if (final_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (accept) begin
      row_d = '0;
      col_d = '0;
    end else if (issue) begin
      if (row_end) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_comb begin
    s2_d  = s2_q;
    s3_d  = s3_q;
    sum_d = sum_q;
    if (pipe_en) begin
      s2_d.valid = issue;
      s2_d.row   = row_q;
      s2_d.col   = col_q;
      s2_d.last  = row_end;
      s2_d.first = (row_q == '0) && (col_q == '0);
      s3_d       = s2_q;
      sum_d      = prod + ADDR_W'(s2_q.col);
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= IDLE;
      rows_q  <= '0;
      width_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
      s2_q    <= '0;
      s3_q    <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      sum_q   <= sum_d;
      if (accept) begin
        rows_q  <= cfg_rows;
        width_q <= cfg_width;
      end
    end
  end

  assign ap_idle       = state_q == IDLE;
  assign ap_done       = done_q;
  assign m_addr_tdata  = sum_q;
  assign m_addr_tvalid = s3_q.valid;
  assign m_addr_tlast  = s3_q.valid && s3_q.last;
  assign m_addr_tuser  = s3_q.valid && s3_q.first;

endmodule

// File: tb/tb_stereolbm_axis_cambm_lbuf_addr_gen.sv
// Scoreboard bench for the line-buffer address generator.
// Stimulus pushes expected beats; a negedge monitor pops and compares.
module tb_stereolbm_axis_cambm_lbuf_addr_gen;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        ap_start = 1'b0;
  logic [5:0]  cfg_rows = '0;
  logic [9:0]  cfg_width = '0;
  logic        ap_idle, ap_done;
  logic [14:0] m_addr_tdata;
  logic        m_addr_tvalid, m_addr_tlast, m_addr_tuser;
  logic        m_addr_tready = 1'b1;

  stereolbm_axis_cambm_lbuf_addr_gen dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .ap_start     (ap_start),
    .cfg_rows     (cfg_rows),
    .cfg_width    (cfg_width),
    .ap_idle      (ap_idle),
    .ap_done      (ap_done),
    .m_addr_tdata (m_addr_tdata),
    .m_addr_tvalid(m_addr_tvalid),
    .m_addr_tready(m_addr_tready),
    .m_addr_tlast (m_addr_tlast),
    .m_addr_tuser (m_addr_tuser)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [14:0] d;
    logic        l;
    logic        u;
    logic        f;
  } exp_t;

  exp_t        q[$];
  logic [14:0] seen[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  int          rdy_mode = 0;
  int          ph = 0;
  logic        fin_prev = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_word = '0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endfunction

  task automatic push(input int r, input int w);
    for (int i = 0; i < r; i++) begin
      for (int j = 0; j < w; j++) begin
        exp_t e;
        e.d = 15'((i * w + j) % 32768);
        e.l = (j == w - 1);
        e.u = (i == 0) && (j == 0);
        e.f = (i == r - 1) && (j == w - 1);
        q.push_back(e);
      end
    end
  endtask

  task automatic start(input int r, input int w, output int lat);
    @(posedge ap_clk); #1;
    cfg_rows  = 6'(r);
    cfg_width = 10'(w);
    ap_start  = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    lat = 1;
    while (!m_addr_tvalid && lat < 10) begin
      @(posedge ap_clk); #1;
      lat++;
    end
  endtask

  task automatic wait_frame(input string nm, input int exp_done, input int budget);
    for (int c = 0; c < budget && done_cnt < exp_done; c++) @(posedge ap_clk);
    repeat (3) @(posedge ap_clk);
    #1;
    chk({nm, "_done_count"}, 32'(done_cnt), 32'(exp_done));
    chk({nm, "_queue_drained"}, 32'(q.size()), 32'd0);
  endtask

  // Ready pattern: always high, or 1,0,0,1 repeating.
  initial begin
    forever begin
      @(posedge ap_clk); #1;
      ph++;
      m_addr_tready = (rdy_mode == 0) || (ph % 4 == 0) || (ph % 4 == 3);
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge ap_clk);
      if (ap_done) done_cnt++;
      if (ap_rst) begin
        fin_prev   = 1'b0;
        stall_prev = 1'b0;
      end else begin
        if (fin_prev) begin
          chk("done_after_last", 32'(ap_done), 32'd1);
          chk("idle_after_last", 32'(ap_idle), 32'd1);
        end
        fin_prev = 1'b0;
        if (stall_prev)
          chk("stall_stable",
              32'({m_addr_tvalid, m_addr_tdata, m_addr_tlast, m_addr_tuser}),
              prev_word);
        if (m_addr_tvalid && m_addr_tready) begin
          hs_cnt++;
          seen.push_back(m_addr_tdata);
          if (q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_beat: got data 0x%0h, expected no beat",
                     m_addr_tdata);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("beat", 32'({m_addr_tdata, m_addr_tlast, m_addr_tuser}),
                32'({e.d, e.l, e.u}));
            fin_prev = e.f;
          end
        end
        stall_prev = m_addr_tvalid && !m_addr_tready;
        prev_word  = 32'({m_addr_tvalid, m_addr_tdata, m_addr_tlast, m_addr_tuser});
      end
    end
  end

  initial begin
    #700000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_chk++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    int lat;
    int d0;
    int h0;

    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_tvalid", 32'(m_addr_tvalid), 32'd0);
    chk("rst_idle", 32'(ap_idle), 32'd1);
    chk("rst_done", 32'(ap_done), 32'd0);
    chk("rst_tdata", 32'(m_addr_tdata), 32'd0);
    chk("rst_tlast", 32'(m_addr_tlast), 32'd0);
    chk("rst_tuser", 32'(m_addr_tuser), 32'd0);
    ap_rst = 1'b0;

    // 4x5, ready always high
    rdy_mode = 0;
    seen.delete();
    d0 = done_cnt;
    push(4, 5);
    start(4, 5, lat);
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_first_tuser", 32'(m_addr_tuser), 32'd1);
    chk("t1_first_tdata", 32'(m_addr_tdata), 32'd0);
    wait_frame("t1", d0 + 1, 200);
    chk("t1_beats", 32'(seen.size()), 32'd20);
    chk("t1_last_addr", 32'(seen[seen.size()-1]), 32'd19);

    // 4x5, ready toggling 1,0,0,1
    rdy_mode = 1;
    seen.delete();
    d0 = done_cnt;
    push(4, 5);
    start(4, 5, lat);
    chk("t2_latency", 32'(lat), 32'd3);
    wait_frame("t2", d0 + 1, 400);
    chk("t2_beats", 32'(seen.size()), 32'd20);
    rdy_mode = 0;

    // 41x1000, product wraps modulo 2^15
    seen.delete();
    d0 = done_cnt;
    push(41, 1000);
    start(41, 1000, lat);
    wait_frame("t3", d0 + 1, 45000);
    chk("t3_beats", 32'(seen.size()), 32'd41000);
    chk("t3_row40_start", 32'(seen[40000]), 32'd7232);
    chk("t3_final", 32'(seen[40999]), 32'd8231);

    // zero rows: no beats, single done pulse
    seen.delete();
    d0 = done_cnt;
    @(posedge ap_clk); #1;
    cfg_rows  = 6'd0;
    cfg_width = 10'd7;
    ap_start  = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    @(negedge ap_clk);
    chk("t4_done", 32'(ap_done), 32'd1);
    chk("t4_idle", 32'(ap_idle), 32'd1);
    repeat (6) @(posedge ap_clk);
    #1;
    chk("t4_done_once", 32'(done_cnt), 32'(d0 + 1));
    chk("t4_no_beats", 32'(seen.size()), 32'd0);
    chk("t4_idle_after", 32'(ap_idle), 32'd1);

    // start mid-frame with other cfg is ignored
    seen.delete();
    d0 = done_cnt;
    push(2, 4);
    start(2, 4, lat);
    cfg_rows  = 6'd5;
    cfg_width = 10'd9;
    ap_start  = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    wait_frame("t5", d0 + 1, 200);
    chk("t5_beats", 32'(seen.size()), 32'd8);
    chk("t5_idle", 32'(ap_idle), 32'd1);

    // async reset at beat 10 of a 3x8 frame
    seen.delete();
    d0 = done_cnt;
    h0 = hs_cnt;
    push(3, 8);
    start(3, 8, lat);
    for (int c = 0; c < 500 && hs_cnt < h0 + 10; c++) @(posedge ap_clk);
    chk("t6_reached_beat10", 32'(hs_cnt >= h0 + 10), 32'd1);
    @(posedge ap_clk); #2;
    ap_rst = 1'b1;
    #1;
    chk("t6_rst_tvalid", 32'(m_addr_tvalid), 32'd0);
    chk("t6_rst_tdata", 32'(m_addr_tdata), 32'd0);
    chk("t6_rst_idle", 32'(ap_idle), 32'd1);
    q.delete();
    seen.delete();
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    repeat (6) @(posedge ap_clk);
    #1;
    chk("t6_no_beats_after_rst", 32'(seen.size()), 32'd0);
    chk("t6_no_done_after_rst", 32'(done_cnt), 32'(d0));
    push(3, 8);
    start(3, 8, lat);
    chk("t6_restart_tuser", 32'(m_addr_tuser), 32'd1);
    chk("t6_restart_tdata", 32'(m_addr_tdata), 32'd0);
    wait_frame("t6", d0 + 1, 300);
    chk("t6_beats", 32'(seen.size()), 32'd24);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stereolbm_axis_cambm_lbuf_addr_gen.md
# stereolbm_axis_cambm_lbuf_addr_gen

Raster-scan line-buffer address generator for the stereo LBM core. On each start it walks a frame of cfg_rows × cfg_width positions and emits one 15-bit linear address per beat, addr = (row × width + col) mod 2^15, on an AXI-Stream-style master port. It feeds the left/right line-buffer read ports. The row × width product is taken through a 6×10→15 unsigned multiply.

## Interface
Parameters:
- ROW_W, 6, row index / row-count width
- COL_W, 10, column index / width field width
- ADDR_W, 15, address width; products and sums truncate to this

Ports:
- ap_clk  in  1  sole clock, rising edge
- ap_rst  in  1  reset, asynchronous, active-high
- ap_start  in  1  frame start request; sampled only in IDLE
- cfg_rows  in  ROW_W  rows per frame; latched on accepted start
- cfg_width  in  COL_W  columns per row (= row stride); latched on accepted start
- ap_idle  out  1  high in IDLE
- ap_done  out  1  one-cycle pulse at frame completion
- m_addr_tdata  out  ADDR_W  linear address
- m_addr_tvalid  out  1  beat valid
- m_addr_tready  in  1  downstream accept
- m_addr_tlast  out  1  last column of a row (col == width-1)
- m_addr_tuser  out  1  first beat of frame (row 0, col 0)

## Operation
- FSM: IDLE, RUN, DRAIN.
- IDLE → RUN on ap_start. cfg_rows and cfg_width are latched, and the row/col counters clear.
- IDLE → DONE path: if a latched dimension is 0, no beats are issued. ap_done pulses the next cycle and the FSM stays in IDLE.
- RUN issues (row, col) into a 3-stage pipeline, one per enabled cycle. Stage 1 is the counters, stage 2 is the registered product row×width, stage 3 is the registered sum + col with tlast/tuser.
- col increments and wraps to 0 at width-1, which increments row. After issuing (rows-1, width-1) the FSM goes RUN → DRAIN.
- DRAIN → IDLE when the final beat (tlast on the last row) handshakes. ap_done pulses in the following cycle and ap_idle rises the same cycle.
- Global stall: pipe_en = !m_addr_tvalid | m_addr_tready. When pipe_en=0, all stage registers and counters hold. tdata, tlast and tuser stay stable while tvalid is high.
- Pipeline bubbles are tracked by per-stage valid bits. Bubbles collapse when pipe_en=1.
- ap_start outside IDLE is ignored. cfg changes outside IDLE have no effect.
- Arithmetic:
  - 16-bit product, truncated to bits [14:0].
  - Sum is 15 bits, with the carry out discarded.
  - All unsigned.

## Timing
- Reset values: ap_idle=1; ap_done=0; m_addr_tvalid=0; tdata=0; tlast=0; tuser=0; FSM=IDLE; counters and stage valids 0.
- Latency: ap_start high in IDLE at cycle T gives the first tvalid at cycle T+3, with tdata=0 and tuser=1.
- Throughput: 1 beat/cycle while tready=1.
- The frame occupies exactly rows×width beats.
- Last handshake at cycle L gives ap_done=1 at L+1 only. A new ap_start is accepted at L+1.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous). No beat is emitted after reset deasserts until a new start.

## Structure
- Package stereolbm_axis_cambm_lbuf_pkg holds:
  - ROW_W, COL_W, ADDR_W localparams
  - FSM state enum {IDLE, RUN, DRAIN}
  - stage record typedef {valid, row, col, last, first}
- One sub-module, stereolbm_axis_cambm_lbuf_mul_reg: unsigned 6×10→15 multiply with output register and enable.

## Test plan
- rows=4, width=5, tready=1 → addresses 0..19 in order. tlast on 4, 9, 14, 19. tuser only on 0. First tvalid 3 cycles after start. ap_done one cycle after beat 19.
- Same config, tready toggling 1,0,0,1 repeating → identical address sequence. No beat dropped or duplicated. tdata stable across stalls.
- rows=41, width=1000 → row 40 starts at 7232 (40000 mod 32768) and the final beat is 8231. Total 41000 beats.
- rows=0, width=7 → no tvalid. ap_done one cycle after start. ap_idle stays 1.
- ap_start pulsed mid-frame with different cfg → ignored; original frame completes unchanged.
- Assert ap_rst at beat 10 of rows=3, width=8 → tvalid drops immediately. The next frame started after reset begins at address 0 with tuser=1.
